// File: rtl/ef_psram_tgt_pkg.sv
// Shared types and constants for the quad-SPI PSRAM target model.
package ef_psram_tgt_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_READ,
    ST_WRITE,
    ST_IGNORE
  } state_t;

  localparam logic [7:0] CMD_QREAD  = 8'hEB;
  localparam logic [7:0] CMD_QWRITE = 8'h38;
  localparam logic [7:0] CMD_QPI_EN = 8'h35;
  localparam logic [7:0] CMD_QPI_EX = 8'hF5;

  localparam int ADDR_NIBBLES = 6;
  localparam int PAGE_AW      = 10;

endpackage

// File: rtl/ef_psram_tgt_sync.sv
// Two-flop synchronisers for sck, ce_n and dio, plus edge pulses taken from the synchronised sck/ce_n.
module ef_psram_tgt_sync (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_sck,
  input  logic       i_ce_n,
  input  logic [3:0] i_dio,
  output logic [3:0] o_dio,
  output logic       o_ce_n,
  output logic       o_sck_rise,
  output logic       o_sck_fall,
  output logic       o_ce_rise,
  output logic       o_ce_fall
);

  logic [2:0] r_sck;
  logic [2:0] r_ce_n;
  logic [3:0] r_dio_meta;
  logic [3:0] r_dio;

  // ce_n chain resets high so leaving reset never fakes a select
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sck      <= 3'b000;
      r_ce_n     <= 3'b111;
      r_dio_meta <= 4'h0;
      r_dio      <= 4'h0;
    end else begin
      r_sck      <= {r_sck[1:0], i_sck};
      r_ce_n     <= {r_ce_n[1:0], i_ce_n};
      r_dio_meta <= i_dio;
      r_dio      <= r_dio_meta;
    end
  end

  assign o_dio      = r_dio;
  assign o_ce_n     = r_ce_n[2];
  assign o_sck_rise =  r_sck[1] & ~r_sck[2];
  assign o_sck_fall = ~r_sck[1] &  r_sck[2];
  assign o_ce_rise  =  r_ce_n[1] & ~r_ce_n[2];
  assign o_ce_fall  = ~r_ce_n[1] &  r_ce_n[2];

endmodule

// File: rtl/ef_psram_qspi_target.sv
// Quad-SPI PSRAM target oversampled by clk. Define EF_PSRAM_TGT_PAGE_WRAP_EN to wrap bursts inside a 1 KiB page.
// IDLE: deselected | CMD: opcode shift | ADDR: 6 addr nibbles | DUMMY: wait | READ: drive data | WRITE: store data | IGNORE: wait for ce_n rise
module ef_psram_qspi_target #(
  parameter int MEM_AW       = 13,
  parameter int DUMMY_CYCLES = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sck,
  input  logic       ce_n,
  input  logic [3:0] dio_i,
  output logic [3:0] dio_o,
  output logic [3:0] dio_oe,
  output logic       qpi_mode,
  output logic       busy,
  output logic       cmd_err
);
  import ef_psram_tgt_pkg::*;

  localparam int CNT_W = 8;
`ifdef EF_PSRAM_TGT_PAGE_WRAP_EN
  localparam logic [MEM_AW-1:0] PAGE_MASK = MEM_AW'((1 << PAGE_AW) - 1);
`endif

  function automatic logic [MEM_AW-1:0] f_inc(input logic [MEM_AW-1:0] a);
`ifdef EF_PSRAM_TGT_PAGE_WRAP_EN
    f_inc = (a & ~PAGE_MASK) | ((a + MEM_AW'(1)) & PAGE_MASK);
`else
    f_inc = a + MEM_AW'(1);
`endif
  endfunction

  logic [3:0] w_dio;
  logic       w_ce_n_d, w_sck_rise, w_sck_fall, w_ce_rise, w_ce_fall;

  ef_psram_tgt_sync u_sync (
    .clk        (clk),
    .rst        (rst),
    .i_sck      (sck),
    .i_ce_n     (ce_n),
    .i_dio      (dio_i),
    .o_dio      (w_dio),
    .o_ce_n     (w_ce_n_d),
    .o_sck_rise (w_sck_rise),
    .o_sck_fall (w_sck_fall),
    .o_ce_rise  (w_ce_rise),
    .o_ce_fall  (w_ce_fall)
  );

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [7:0]         r_cmd;
  logic [MEM_AW-1:0]  r_addr;
  logic               r_phase;
  logic [3:0]         r_wr_hi;
  logic [7:0]         r_rdata;
  logic [3:0]         r_dout;
  logic               r_qpi;
  logic               r_err;
  logic [7:0]         r_mem [0:(1<<MEM_AW)-1];

  logic [7:0]         w_cmd_nxt;
  logic               w_cmd_last;
  logic [MEM_AW-1:0]  w_addr_sh, w_rd_addr;
  logic w_cnt_clr, w_cnt_inc, w_cmd_shift, w_addr_shift, w_qpi_set, w_qpi_clr;
  logic w_err, w_fetch, w_wr_hi, w_wr_commit, w_drive;

  assign w_cmd_nxt  = r_qpi ? {r_cmd[3:0], w_dio} : {r_cmd[6:0], w_dio[0]};
  assign w_cmd_last = (r_cnt == (r_qpi ? CNT_W'(1) : CNT_W'(7)));
  assign w_addr_sh  = {r_addr[MEM_AW-5:0], w_dio};
  // the first fetch of a zero-dummy read happens while the last address nibble is still being shifted in
  assign w_rd_addr  = (r_state == ST_ADDR) ? w_addr_sh : r_addr;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_clr    = 1'b0;
    w_cnt_inc    = 1'b0;
    w_cmd_shift  = 1'b0;
    w_addr_shift = 1'b0;
    w_qpi_set    = 1'b0;
    w_qpi_clr    = 1'b0;
    w_err        = 1'b0;
    w_fetch      = 1'b0;
    w_wr_hi      = 1'b0;
    w_wr_commit  = 1'b0;
    w_drive      = 1'b0;
    if (w_ce_rise) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (w_ce_fall) begin
          w_state_nxt = ST_CMD;
          w_cnt_clr   = 1'b1;
        end
        ST_CMD: if (w_sck_rise) begin
          w_cmd_shift = 1'b1;
          w_cnt_inc   = 1'b1;
          if (w_cmd_last) begin
            w_cnt_clr   = 1'b1;
            w_state_nxt = ST_IGNORE;
            case (w_cmd_nxt)
              CMD_QREAD, CMD_QWRITE: w_state_nxt = ST_ADDR;
              CMD_QPI_EN:            w_qpi_set   = 1'b1;
              CMD_QPI_EX: begin
                if (r_qpi) w_qpi_clr = 1'b1;
                else       w_err     = 1'b1;
              end
              default:               w_err       = 1'b1;
            endcase
          end
        end
        ST_ADDR: if (w_sck_rise) begin
          w_addr_shift = 1'b1;
          w_cnt_inc    = 1'b1;
          if (r_cnt == CNT_W'(ADDR_NIBBLES - 1)) begin
            w_cnt_clr = 1'b1;
            if (r_cmd == CMD_QWRITE) begin
              w_state_nxt = ST_WRITE;
            end else if (DUMMY_CYCLES == 0) begin
              w_state_nxt = ST_READ;
              w_fetch     = 1'b1;
            end else begin
              w_state_nxt = ST_DUMMY;
            end
          end
        end
        ST_DUMMY: if (w_sck_rise) begin
          w_cnt_inc = 1'b1;
          if (r_cnt == CNT_W'(DUMMY_CYCLES - 1)) begin
            w_cnt_clr   = 1'b1;
            w_state_nxt = ST_READ;
            w_fetch     = 1'b1;
          end
        end
        ST_READ: begin
          if (w_sck_rise && !r_phase) w_fetch = 1'b1;
          if (w_sck_fall)             w_drive = 1'b1;
        end
        ST_WRITE: if (w_sck_rise) begin
          if (!r_phase) w_wr_hi     = 1'b1;
          else          w_wr_commit = 1'b1;
        end
        ST_IGNORE: w_state_nxt = ST_IGNORE;
        default:   w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_cmd   <= 8'h00;
      r_addr  <= '0;
      r_phase <= 1'b0;
      r_wr_hi <= 4'h0;
      r_dout  <= 4'h0;
      r_qpi   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_err <= w_err;
      if (w_qpi_set)      r_qpi <= 1'b1;
      else if (w_qpi_clr) r_qpi <= 1'b0;
      if (w_cnt_clr)      r_cnt <= '0;
      else if (w_cnt_inc) r_cnt <= r_cnt + CNT_W'(1);
      if (w_cnt_clr)                              r_phase <= 1'b0;
      else if (w_drive || w_wr_hi || w_wr_commit) r_phase <= ~r_phase;
      if (w_cmd_shift)  r_cmd  <= w_cmd_nxt;
      if (w_addr_shift) r_addr <= w_addr_sh;
      if (w_fetch)          r_addr <= f_inc(w_rd_addr);
      else if (w_wr_commit) r_addr <= f_inc(r_addr);
      if (w_wr_hi) r_wr_hi <= w_dio;
      if (w_drive) r_dout  <= r_phase ? r_rdata[3:0] : r_rdata[7:4];
    end
  end

  // array contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (w_wr_commit && !rst) r_mem[r_addr] <= {r_wr_hi, w_dio};
    if (w_fetch) r_rdata <= r_mem[w_rd_addr];
  end

  assign dio_o    = r_dout;
  assign dio_oe   = (r_state == ST_READ) ? 4'hF : 4'h0;
  assign qpi_mode = r_qpi;
  assign busy     = ~w_ce_n_d;
  assign cmd_err  = r_err;

endmodule
